// File: rtl/buffer_pkg.sv
// Shared sizing, types and helpers for the packet buffer controller and its byte RAM.
package buffer_pkg;

  localparam int BUFFER_SIZE = 32;
  localparam int PACKET_SIZE = 402;

  localparam int PACKET_AW = $clog2(PACKET_SIZE);
  localparam int BUFFER_AW = $clog2(BUFFER_SIZE);
  localparam int COUNT_W   = BUFFER_AW + 1;
  localparam int RAM_AW    = BUFFER_AW + PACKET_AW;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef logic [7:0]           TypeByte;
  typedef logic [PACKET_AW-1:0] TypePacketAddr;
  typedef logic [BUFFER_AW-1:0] TypeBufferAddr;
  typedef logic [COUNT_W-1:0]   TypeCount;

  // True when a byte offset falls inside a packet slot.
  function automatic logic inPacket(input TypePacketAddr addr);
    return addr < TypePacketAddr'(PACKET_SIZE);
  endfunction

  // Slot length after a byte lands at addr: lengths only ever grow.
  function automatic TypePacketAddr lenAfterWrite(input TypePacketAddr curLen,
                                                  input TypePacketAddr addr);
    TypePacketAddr reach;
    reach = addr + TypePacketAddr'(1);
    return (reach > curLen) ? reach : curLen;
  endfunction

endpackage

// File: rtl/buffer_ram.sv
// Simple dual-port byte RAM: one write port and one registered read port.
// Reads return the old contents when written in the same cycle.
module buffer_ram
  import buffer_pkg::*;
(
  input  logic              clock,
  input  logic              writeEnable,
  input  logic [RAM_AW-1:0] writeAddr,
  input  logic [7:0]        writeData,
  input  logic [RAM_AW-1:0] readAddr,
  output logic [7:0]        readData
);

  TypeByte mem [RAM_DEPTH];

  // Byte write port.
  always_ff @(posedge clock) begin
    if (writeEnable) begin
      mem[writeAddr] <= writeData;
    end
  end

  // Registered read port, sees pre-write contents on address collisions.
  always_ff @(posedge clock) begin
    readData <= mem[readAddr];
  end

endmodule

// File: rtl/buffer_cntr.sv
// Packet FIFO controller: allocates write slots for the receiver, hands slots to
// the reader in allocation order, and tracks per-slot lengths and occupancy.
module buffer_cntr
  import buffer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_port,
  output logic                 done_port,
  input  logic                 recv_next,
  output logic                 recv_next_ack,
  output logic                 recv_next_ok,
  input  logic                 recv_we,
  input  logic [PACKET_AW-1:0] recv_addr,
  input  logic [7:0]           recv_data,
  output logic [PACKET_AW-1:0] recv_len,
  input  logic                 read_next,
  output logic                 read_next_ack,
  output logic                 read_next_ok,
  input  logic [PACKET_AW-1:0] read_addr,
  output logic [7:0]           read_data,
  output logic [PACKET_AW-1:0] read_len
);

  TypeBufferAddr wrPtr;
  TypeBufferAddr rdPtr;
  TypeBufferAddr curWr;
  TypeBufferAddr curRd;
  logic          wrActive;
  logic          rdActive;
  TypeCount      count;
  TypePacketAddr lenTable [BUFFER_SIZE];

  logic    allocReq;
  logic    allocOk;
  logic    readReq;
  logic    releaseSlot;
  logic    acquireOk;
  logic    writeHit;
  logic    readValid;
  TypeByte ramData;

  // Decode strobes; fullness uses the registered count so a same-cycle release cannot make room.
  always_comb begin
    allocReq    = start_port & recv_next;
    allocOk     = allocReq && (count < TypeCount'(BUFFER_SIZE));
    readReq     = start_port & read_next;
    releaseSlot = readReq & rdActive;
    acquireOk   = readReq && ((count - TypeCount'(rdActive)) != '0);
    writeHit    = start_port & recv_we & wrActive & inPacket(recv_addr);
  end

  // Slot pointers, active flags and the net occupancy count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      curWr    <= '0;
      curRd    <= '0;
      wrActive <= 1'b0;
      rdActive <= 1'b0;
      count    <= '0;
    end else begin
      if (allocOk) begin
        curWr    <= wrPtr;
        wrPtr    <= wrPtr + TypeBufferAddr'(1);
        wrActive <= 1'b1;
      end
      if (readReq) begin
        if (acquireOk) begin
          curRd    <= rdPtr;
          rdPtr    <= rdPtr + TypeBufferAddr'(1);
          rdActive <= 1'b1;
        end else begin
          rdActive <= 1'b0;
        end
      end
      count <= count + TypeCount'(allocOk) - TypeCount'(releaseSlot);
    end
  end

  // Handshake pulses, one clock after each accepted strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      recv_next_ack <= 1'b0;
      recv_next_ok  <= 1'b0;
      read_next_ack <= 1'b0;
      read_next_ok  <= 1'b0;
    end else begin
      recv_next_ack <= allocReq;
      recv_next_ok  <= allocOk;
      read_next_ack <= readReq;
      read_next_ok  <= acquireOk;
    end
  end

  // Per-slot lengths: grow on writes, cleared when a slot is freshly allocated.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        lenTable[i] <= '0;
      end
    end else begin
      if (writeHit) begin
        lenTable[curWr] <= lenAfterWrite(lenTable[curWr], recv_addr);
      end
      if (allocOk) begin
        lenTable[wrPtr] <= '0;
      end
    end
  end

  // Remembers whether the address presented last cycle should return real data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readValid <= 1'b0;
    end else begin
      readValid <= rdActive & inPacket(read_addr);
    end
  end

  // Status and length outputs, masked to zero for inactive slots.
  always_comb begin
    done_port = start_port && (count == '0);
    recv_len  = wrActive ? lenTable[curWr] : '0;
    read_len  = rdActive ? lenTable[curRd] : '0;
    read_data = readValid ? ramData : 8'h00;
  end

  buffer_ram ram (
    .clock       (clock),
    .writeEnable (writeHit),
    .writeAddr   ({curWr, recv_addr}),
    .writeData   (recv_data),
    .readAddr    ({curRd, read_addr}),
    .readData    (ramData)
  );

endmodule

// File: tb/tb_buffer_cntr.sv
// Directed bench for buffer_cntr: handshake results and read bytes go through a
// scoreboard, lengths and status are checked directly after each step.
module tb_buffer_cntr;
  import buffer_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 start_port = 1'b0;
  logic                 done_port;
  logic                 recv_next = 1'b0;
  logic                 recv_next_ack;
  logic                 recv_next_ok;
  logic                 recv_we = 1'b0;
  logic [PACKET_AW-1:0] recv_addr = '0;
  logic [7:0]           recv_data = '0;
  logic [PACKET_AW-1:0] recv_len;
  logic                 read_next = 1'b0;
  logic                 read_next_ack;
  logic                 read_next_ok;
  logic [PACKET_AW-1:0] read_addr = '0;
  logic [7:0]           read_data;
  logic [PACKET_AW-1:0] read_len;

  int vectors = 0;
  int miscompares = 0;

  logic       readReq = 1'b0;
  logic       readReqD = 1'b0;
  logic       recvOkQ [$];
  logic       readOkQ [$];
  logic [7:0] dataQ [$];

  buffer_cntr dut (
    .clock         (clock),
    .reset         (reset),
    .start_port    (start_port),
    .done_port     (done_port),
    .recv_next     (recv_next),
    .recv_next_ack (recv_next_ack),
    .recv_next_ok  (recv_next_ok),
    .recv_we       (recv_we),
    .recv_addr     (recv_addr),
    .recv_data     (recv_data),
    .recv_len      (recv_len),
    .read_next     (read_next),
    .read_next_ack (read_next_ack),
    .read_next_ok  (read_next_ok),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .read_len      (read_len)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Remember which edges carried a read request so the monitor knows when data is due.
  always @(posedge clock) readReqD <= readReq;

  // Scoreboard monitor: pops an expectation whenever the DUT presents a result.
  always @(negedge clock) begin
    logic expOk;
    logic [7:0] expData;
    if (recv_next_ack) begin
      if (recvOkQ.size() == 0) begin
        checkOutput("recvAckUnexpected", 1, 0);
      end else begin
        expOk = recvOkQ.pop_front();
        checkOutput("recvNextOk", int'(recv_next_ok), int'(expOk));
      end
    end
    if (read_next_ack) begin
      if (readOkQ.size() == 0) begin
        checkOutput("readAckUnexpected", 1, 0);
      end else begin
        expOk = readOkQ.pop_front();
        checkOutput("readNextOk", int'(read_next_ok), int'(expOk));
      end
    end
    if (readReqD && dataQ.size() != 0) begin
      expData = dataQ.pop_front();
      checkOutput("readData", int'(read_data), int'(expData));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one cycle of strobes, then returns everything to idle.
  task automatic applyStimulus(input logic rn, input logic rdn, input logic we,
                               input int wa, input int wd, input logic rd, input int ra);
    recv_next = rn;
    read_next = rdn;
    recv_we   = we;
    recv_addr = PACKET_AW'(wa);
    recv_data = 8'(wd);
    readReq   = rd;
    read_addr = PACKET_AW'(ra);
    tick();
    recv_next = 1'b0;
    read_next = 1'b0;
    recv_we   = 1'b0;
    readReq   = 1'b0;
  endtask

  task automatic recvNext(input logic expOk);
    recvOkQ.push_back(expOk);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic readNext(input logic expOk);
    readOkQ.push_back(expOk);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic writeByte(input int addr, input int data);
    applyStimulus(0, 0, 1, addr, data, 0, 0);
  endtask

  task automatic readByte(input int addr, input int expData);
    dataQ.push_back(8'(expData));
    applyStimulus(0, 0, 0, 0, 0, 1, addr);
  endtask

  task automatic pulseReset();
    #2 reset = 1'b0;
    #3 reset = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state with the block disabled.
    #12;
    checkOutput("rstDone", int'(done_port), 0);
    checkOutput("rstRecvAck", int'(recv_next_ack), 0);
    checkOutput("rstReadAck", int'(read_next_ack), 0);
    checkOutput("rstReadData", int'(read_data), 0);
    checkOutput("rstRecvLen", int'(recv_len), 0);
    checkOutput("rstReadLen", int'(read_len), 0);
    reset = 1'b1;
    tick();

    // Strobes are ignored while start_port is low.
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("idleRecvAck", int'(recv_next_ack), 0);
    checkOutput("idleReadAck", int'(read_next_ack), 0);
    start_port = 1'b1;
    #1;
    checkOutput("emptyDone", int'(done_port), 1);

    // Two packets in, two packets out.
    recvNext(1);
    checkOutput("pkt0LenStart", int'(recv_len), 0);
    for (int i = 0; i < 8; i++) writeByte(i, 8'h2C + i);
    checkOutput("pkt0Len", int'(recv_len), 8);
    checkOutput("busyDone", int'(done_port), 0);
    recvNext(1);
    checkOutput("pkt1LenStart", int'(recv_len), 0);
    for (int i = 0; i < 4; i++) writeByte(i, 8'h90 + i);
    checkOutput("pkt1Len", int'(recv_len), 4);
    readNext(1);
    checkOutput("readLen0", int'(read_len), 8);
    for (int i = 0; i < 8; i++) readByte(i, 8'h2C + i);
    readByte(402, 0);
    readNext(1);
    checkOutput("readLen1", int'(read_len), 4);
    for (int i = 0; i < 4; i++) readByte(i, 8'h90 + i);
    readNext(0);
    checkOutput("drainedReadLen", int'(read_len), 0);
    checkOutput("drainedDone", int'(done_port), 1);
    readByte(0, 0);

    // Fill to capacity, reject, concurrent release, wrap the write pointer.
    pulseReset();
    for (int i = 0; i < BUFFER_SIZE; i++) recvNext(1);
    checkOutput("fullDone", int'(done_port), 0);
    recvNext(0);
    writeByte(2, 8'hAB);
    checkOutput("slot31Len", int'(recv_len), 3);
    readNext(1);
    checkOutput("slot0ReadLen", int'(read_len), 0);
    recvOkQ.push_back(1'b0);
    readOkQ.push_back(1'b1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    recvNext(1);
    checkOutput("wrapLenStart", int'(recv_len), 0);
    writeByte(5, 8'h5A);
    checkOutput("offset5Len", int'(recv_len), 6);
    writeByte(402, 8'hFF);
    checkOutput("outOfRangeLen", int'(recv_len), 6);
    recvNext(0);
    for (int i = 0; i < 30; i++) readNext(1);
    checkOutput("slot31ReadLen", int'(read_len), 3);
    readByte(2, 8'hAB);
    readNext(1);
    checkOutput("wrappedReadLen", int'(read_len), 6);
    readByte(5, 8'h5A);
    readNext(0);
    checkOutput("wrapDrainDone", int'(done_port), 1);

    // Reset in the middle of a packet discards everything.
    recvNext(1);
    writeByte(0, 8'h77);
    pulseReset();
    checkOutput("midRstDone", int'(done_port), 1);
    checkOutput("midRstRecvLen", int'(recv_len), 0);
    readNext(0);
    checkOutput("midRstReadLen", int'(read_len), 0);

    // Reader shares the open write slot: read-first collision, later writes visible.
    recvNext(1);
    writeByte(0, 8'h11);
    readNext(1);
    checkOutput("sharedReadLen", int'(read_len), 1);
    dataQ.push_back(8'h11);
    applyStimulus(0, 0, 1, 0, 8'h22, 1, 0);
    readByte(0, 8'h22);

    // Every expected handshake and byte must have been seen.
    tick();
    tick();
    checkOutput("recvQueueLeft", recvOkQ.size(), 0);
    checkOutput("readQueueLeft", readOkQ.size(), 0);
    checkOutput("dataQueueLeft", dataQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
